// File: rtl/sc_regserial_tx.sv
// Parallel-to-serial frame transmitter: captures the register word on a low send request,
// then shifts out start bit, DATAWIDTH data bits LSB first and a stop bit, BAUD_DIV clocks each.
module sc_regserial_tx #(
  parameter int DATAWIDTH = 8,
  parameter int BAUD_DIV  = 4
) (
  input  logic                 SC_REGSERIALTX_CLOCK_50,
  input  logic                 SC_REGSERIALTX_RESET_InLow,
  input  logic                 SC_REGSERIALTX_send_InLow,
  input  logic [DATAWIDTH-1:0] SC_REGSERIALTX_data_InBUS,
  output logic                 SC_REGSERIALTX_serial_Out,
  output logic                 SC_REGSERIALTX_busy_Out,
  output logic                 SC_REGSERIALTX_ack_OutLow,
  output logic                 SC_REGSERIALTX_done_OutLow
);

  localparam int BIT_W  = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATAWIDTH - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Handshake: send_InLow is a level request sampled only in IDLE; the edge that samples it
  // low captures data_InBUS, and ack_OutLow is low for exactly the following cycle.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    ack_d    = 1'b1;
    done_d   = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d   = '0;
        bit_d    = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (!SC_REGSERIALTX_send_InLow) begin
          shift_d  = SC_REGSERIALTX_data_InBUS;
          state_d  = START;
          serial_d = 1'b0;
          busy_d   = 1'b1;
          ack_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = DATA;
          serial_d = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            bit_d    = bit_q + BIT_W'(1);
            serial_d = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d  = IDLE;
          baud_d   = '0;
          bit_d    = '0;
          serial_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SC_REGSERIALTX_CLOCK_50 or negedge SC_REGSERIALTX_RESET_InLow) begin
    if (!SC_REGSERIALTX_RESET_InLow) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b1;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
    end
  end

  assign SC_REGSERIALTX_serial_Out  = serial_q;
  assign SC_REGSERIALTX_busy_Out    = busy_q;
  assign SC_REGSERIALTX_ack_OutLow  = ack_q;
  assign SC_REGSERIALTX_done_OutLow = done_q;

endmodule

// File: tb/tb_sc_regserial_tx.sv
// Bench for sc_regserial_tx: an 8-bit/baud-4 instance and a 4-bit/baud-2 instance,
// checked cycle by cycle against a frame-level model of line, busy, ack and done.
module tb_sc_regserial_tx;

  localparam int DW_A = 8;
  localparam int B_A  = 4;
  localparam int F_A  = (DW_A + 2) * B_A;
  localparam int DW_B = 4;
  localparam int B_B  = 2;
  localparam int F_B  = (DW_B + 2) * B_B;
  localparam logic [3:0] IDLE_OBS = 4'b1011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_send, a_serial, a_busy, a_ack, a_done;
  logic [7:0] a_data;
  logic       b_send, b_serial, b_busy, b_ack, b_done;
  logic [3:0] b_data;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  sc_regserial_tx #(.DATAWIDTH(DW_A), .BAUD_DIV(B_A)) dut_a (
    .SC_REGSERIALTX_CLOCK_50   (clk),
    .SC_REGSERIALTX_RESET_InLow(rst_n),
    .SC_REGSERIALTX_send_InLow (a_send),
    .SC_REGSERIALTX_data_InBUS (a_data),
    .SC_REGSERIALTX_serial_Out (a_serial),
    .SC_REGSERIALTX_busy_Out   (a_busy),
    .SC_REGSERIALTX_ack_OutLow (a_ack),
    .SC_REGSERIALTX_done_OutLow(a_done)
  );

  sc_regserial_tx #(.DATAWIDTH(DW_B), .BAUD_DIV(B_B)) dut_b (
    .SC_REGSERIALTX_CLOCK_50   (clk),
    .SC_REGSERIALTX_RESET_InLow(rst_n),
    .SC_REGSERIALTX_send_InLow (b_send),
    .SC_REGSERIALTX_data_InBUS (b_data),
    .SC_REGSERIALTX_serial_Out (b_serial),
    .SC_REGSERIALTX_busy_Out   (b_busy),
    .SC_REGSERIALTX_ack_OutLow (b_ack),
    .SC_REGSERIALTX_done_OutLow(b_done)
  );

  // Reference model: {serial, busy, ack_n, done_n} in cycle j after the capturing edge
  // (j=1 is the first start-bit cycle). The frame is a list of bit slots of b cycles each:
  // slot 0 start (0), slots 1..dw data LSB first, slot dw+1 stop (1).
  function automatic logic [3:0] exp_obs(input int data, input int dw, input int b, input int j);
    int f;
    int slot;
    logic line;
    f = (dw + 2) * b;
    if (j <= 0 || j > f + 1) return IDLE_OBS;
    slot = (j - 1) / b;
    if (slot == 0) line = 1'b0;
    else if (slot <= dw) line = ((data >> (slot - 1)) & 1) != 0;
    else line = 1'b1;
    return {line, (j <= f), (j != 1), (j != f + 1)};
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    a_send = 1'b1;
    a_data = '0;
    b_send = 1'b1;
    b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_serial, a_busy, a_ack, a_done} !== IDLE_OBS) begin
      errors++;
      $display("FAIL reset_a obs=%b exp=%b", {a_serial, a_busy, a_ack, a_done}, IDLE_OBS);
    end
    checks++;
    if ({b_serial, b_busy, b_ack, b_done} !== IDLE_OBS) begin
      errors++;
      $display("FAIL reset_b obs=%b exp=%b", {b_serial, b_busy, b_ack, b_done}, IDLE_OBS);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({a_serial, a_busy, a_ack, a_done} !== IDLE_OBS ||
          {b_serial, b_busy, b_ack, b_done} !== IDLE_OBS) begin
        errors++;
        $display("FAIL idle c=%0d a=%b b=%b exp=%b", c, {a_serial, a_busy, a_ack, a_done},
                 {b_serial, b_busy, b_ack, b_done}, IDLE_OBS);
      end
    end
  endtask

  task automatic test_single_a5();
    a_send = 1'b0;
    a_data = 8'hA5;
    for (int j = 1; j <= F_A + 2; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) a_send = 1'b1;
      checks++;
      if ({a_serial, a_busy, a_ack, a_done} !== exp_obs(8'hA5, DW_A, B_A, j)) begin
        errors++;
        $display("FAIL single_a5 j=%0d obs=%b exp=%b", j, {a_serial, a_busy, a_ack, a_done},
                 exp_obs(8'hA5, DW_A, B_A, j));
      end
    end
  endtask

  task automatic test_mid_frame_changes();
    a_send = 1'b0;
    a_data = 8'h0F;
    for (int j = 1; j <= F_A + 3; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({a_serial, a_busy, a_ack, a_done} !== exp_obs(8'h0F, DW_A, B_A, j)) begin
        errors++;
        $display("FAIL mid_frame j=%0d obs=%b exp=%b", j, {a_serial, a_busy, a_ack, a_done},
                 exp_obs(8'h0F, DW_A, B_A, j));
      end
      if (j == 1 || j == 8 || j == 25) a_send = 1'b1;
      if (j == 5 || j == 20) a_send = 1'b0;
      if (j == 10) a_data = 8'hF0;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    a_send = 1'b0;
    a_data = 8'h01;
    for (int j = 1; j <= 2 * F_A + 3; j++) begin
      @(posedge clk);
      #1;
      e = (j <= F_A + 1) ? exp_obs(8'h01, DW_A, B_A, j) : exp_obs(8'h80, DW_A, B_A, j - (F_A + 1));
      checks++;
      if ({a_serial, a_busy, a_ack, a_done} !== e) begin
        errors++;
        $display("FAIL back_to_back j=%0d obs=%b exp=%b", j, {a_serial, a_busy, a_ack, a_done}, e);
      end
      if (j == 5) a_data = 8'h80;
      if (j == F_A + 2) a_send = 1'b1;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    a_send = 1'b0;
    a_data = d;
    for (int j = 1; j <= 18; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) a_send = 1'b1;
      checks++;
      if ({a_serial, a_busy, a_ack, a_done} !== exp_obs(d, DW_A, B_A, j)) begin
        errors++;
        $display("FAIL pre_reset j=%0d obs=%b exp=%b", j, {a_serial, a_busy, a_ack, a_done},
                 exp_obs(d, DW_A, B_A, j));
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_serial, a_busy, a_ack, a_done} !== IDLE_OBS) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", {a_serial, a_busy, a_ack, a_done}, IDLE_OBS);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({a_serial, a_busy, a_ack, a_done} !== IDLE_OBS) begin
        errors++;
        $display("FAIL post_reset_idle c=%0d obs=%b exp=%b", c, {a_serial, a_busy, a_ack, a_done},
                 IDLE_OBS);
      end
    end
    d = 8'($urandom_range(0, 255));
    a_send = 1'b0;
    a_data = d;
    for (int j = 1; j <= F_A + 2; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) a_send = 1'b1;
      checks++;
      if ({a_serial, a_busy, a_ack, a_done} !== exp_obs(d, DW_A, B_A, j)) begin
        errors++;
        $display("FAIL fresh_frame j=%0d obs=%b exp=%b", j, {a_serial, a_busy, a_ack, a_done},
                 exp_obs(d, DW_A, B_A, j));
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    int gap;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      a_send = 1'b0;
      a_data = d;
      for (int j = 1; j <= F_A + 1 + gap; j++) begin
        @(posedge clk);
        #1;
        if (j == 1) a_send = 1'b1;
        if (j == 2) a_data = 8'($urandom_range(0, 255));
        checks++;
        if ({a_serial, a_busy, a_ack, a_done} !== exp_obs(d, DW_A, B_A, j)) begin
          errors++;
          $display("FAIL random n=%0d d=%02h j=%0d obs=%b exp=%b", n, d, j,
                   {a_serial, a_busy, a_ack, a_done}, exp_obs(d, DW_A, B_A, j));
        end
      end
    end
  endtask

  task automatic test_small_config();
    b_send = 1'b0;
    b_data = 4'h9;
    for (int j = 1; j <= F_B + 2; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) b_send = 1'b1;
      checks++;
      if ({b_serial, b_busy, b_ack, b_done} !== exp_obs(4'h9, DW_B, B_B, j)) begin
        errors++;
        $display("FAIL small_cfg j=%0d obs=%b exp=%b", j, {b_serial, b_busy, b_ack, b_done},
                 exp_obs(4'h9, DW_B, B_B, j));
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_a5();
    test_mid_frame_changes();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    test_small_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
